// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU sitting between issue and writeback.
// Single-cycle ops finish at the accept edge. MUL, DIVU and REMU run one
// shift-add or restoring-subtract step per cycle. WIDTH must be a power of 2, >= 4.
module alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             negative_flag,
  output logic             div_zero_flag
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_ADD   = 4'd0;
  localparam logic [OPW-1:0] OP_SUB   = 4'd1;
  localparam logic [OPW-1:0] OP_AND   = 4'd2;
  localparam logic [OPW-1:0] OP_OR    = 4'd3;
  localparam logic [OPW-1:0] OP_XOR   = 4'd4;
  localparam logic [OPW-1:0] OP_NOT   = 4'd5;
  localparam logic [OPW-1:0] OP_SHL   = 4'd6;
  localparam logic [OPW-1:0] OP_SHR   = 4'd7;
  localparam logic [OPW-1:0] OP_CMPEQ = 4'd8;
  localparam logic [OPW-1:0] OP_CMPLT = 4'd9;
  localparam logic [OPW-1:0] OP_CMPLE = 4'd10;
  localparam logic [OPW-1:0] OP_MUL   = 4'd11;
  localparam logic [OPW-1:0] OP_DIVU  = 4'd12;
  localparam logic [OPW-1:0] OP_REMU  = 4'd13;
  localparam logic [OPW-1:0] OP_ASR   = 4'd14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;

  // Working registers shared by multiply and divide.
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  // Presented result and flags.
  logic [WIDTH-1:0] res_q, res_d;
  logic             zf_q, zf_d;
  logic             cf_q, cf_d;
  logic             vf_q, vf_d;
  logic             nf_q, nf_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic             is_iter_in;
  logic             is_div_q;
  logic             div_by_zero;
  logic             last_step;
  logic             busy_done;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [SHW-1:0]   sh;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] hi_step;
  logic [WIDTH-1:0] lo_step;
  logic [WIDTH-1:0] iter_res;
  logic             iter_hi_nz;

  logic             load_res;
  logic [WIDTH-1:0] res_nxt;
  logic             c_nxt;
  logic             v_nxt;
  logic             dz_nxt;

  assign accept      = in_ready_q & in_valid;
  assign is_iter_in  = (op_code == OP_MUL) | (op_code == OP_DIVU) | (op_code == OP_REMU);
  assign is_div_q    = (op_q == OP_DIVU) | (op_q == OP_REMU);
  assign div_by_zero = is_div_q & (opnd_q == '0);
  assign last_step   = (cnt_q == SHW'(WIDTH - 1));
  assign busy_done   = (state_q == S_BUSY) & (div_by_zero | last_step);

  // State register plus the registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid)  state_d = is_iter_in ? S_BUSY : S_DONE;
      S_BUSY:  if (busy_done) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs follow the upcoming state so they are registered.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    if (state_d == S_IDLE) in_ready_d  = 1'b1;
    if (state_d == S_DONE) out_valid_d = 1'b1;
  end

  // Single-cycle ALU on the live inputs, registered at the accept edge.
  always_comb begin
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} - {1'b0, b};
    sh       = b[SHW-1:0];
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    unique case (op_code)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_XOR:   alu_res = a ^ b;
      OP_NOT:   alu_res = ~a;
      OP_SHL:   alu_res = a << sh;
      OP_SHR:   alu_res = a >> sh;
      OP_ASR:   alu_res = $signed(a) >>> sh;
      OP_CMPEQ: alu_res = WIDTH'(a == b);
      OP_CMPLT: alu_res = WIDTH'($signed(a) <  $signed(b));
      OP_CMPLE: alu_res = WIDTH'($signed(a) <= $signed(b));
      default:  alu_res = '0;
    endcase
  end

  // One iteration step: shift-add multiply or restoring divide.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {WIDTH{1'b0}})};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    if (op_q == OP_MUL) begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_step = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
    end
    iter_res   = (op_q == OP_REMU) ? hi_step : lo_step;
    iter_hi_nz = (op_q == OP_MUL) && (hi_step != '0);
  end

  // Working-register and result/flag next values.
  always_comb begin
    op_d     = op_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    vf_d     = vf_q;
    nf_d     = nf_q;
    dz_d     = dz_q;
    load_res = 1'b0;
    res_nxt  = '0;
    c_nxt    = 1'b0;
    v_nxt    = 1'b0;
    dz_nxt   = 1'b0;

    if (accept) begin
      op_d   = op_code;
      cnt_d  = '0;
      hi_d   = '0;
      lo_d   = (op_code == OP_MUL) ? b : a;
      opnd_d = (op_code == OP_MUL) ? a : b;
      if (!is_iter_in) begin
        load_res = 1'b1;
        res_nxt  = alu_res;
        c_nxt    = alu_c;
        v_nxt    = alu_v;
      end
    end

    if (state_q == S_BUSY) begin
      if (div_by_zero) begin
        load_res = 1'b1;
        res_nxt  = (op_q == OP_DIVU) ? {WIDTH{1'b1}} : lo_q;
        dz_nxt   = 1'b1;
      end else begin
        hi_d  = hi_step;
        lo_d  = lo_step;
        cnt_d = cnt_q + SHW'(1);
        if (last_step) begin
          load_res = 1'b1;
          res_nxt  = iter_res;
          c_nxt    = iter_hi_nz;
          v_nxt    = iter_hi_nz;
        end
      end
    end

    if (load_res) begin
      res_d = res_nxt;
      zf_d  = (res_nxt == '0);
      nf_d  = res_nxt[WIDTH-1];
      cf_d  = c_nxt;
      vf_d  = v_nxt;
      dz_d  = dz_nxt;
    end
  end

  // Datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      zf_q   <= 1'b1;
      cf_q   <= 1'b0;
      vf_q   <= 1'b0;
      nf_q   <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      op_q   <= op_d;
      opnd_q <= opnd_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
      zf_q   <= zf_d;
      cf_q   <= cf_d;
      vf_q   <= vf_d;
      nf_q   <= nf_d;
      dz_q   <= dz_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign result        = res_q;
  assign zero_flag     = zf_q;
  assign carry_flag    = cf_q;
  assign overflow_flag = vf_q;
  assign negative_flag = nf_q;
  assign div_zero_flag = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: WIDTH=16 and WIDTH=32 instances against an arithmetic model.
module tb_alu_seq;

  logic        clk;
  logic        reset_n;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, result16;
  logic [3:0]  op16;
  logic        z16, c16, v16, n16, dz16;

  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] a32, b32, result32;
  logic [3:0]  op32;
  logic        z32, c32, v32, n32, dz32;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [63:0] res;
    logic        c;
    logic        v;
    logic        dz;
    int          lat;
  } exp_t;

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op_code(op16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .result(result16), .zero_flag(z16), .carry_flag(c16),
    .overflow_flag(v16), .negative_flag(n16), .div_zero_flag(dz16)
  );

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .op_code(op32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .result(result32), .zero_flag(z32), .carry_flag(c32),
    .overflow_flag(v32), .negative_flag(n32), .div_zero_flag(dz32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference behaviour at width w (w <= 32), computed with plain wide arithmetic.
  function automatic exp_t model(input int w, input logic [3:0] op,
                                 input logic [63:0] ia, input logic [63:0] ib);
    exp_t        e;
    logic [63:0] mask, full;
    longint      sa, sb, smax, smin, s;
    int          sh;
    mask = (64'd1 << w) - 64'd1;
    sa   = ia[w-1] ? longint'(ia) - (longint'(1) << w) : longint'(ia);
    sb   = ib[w-1] ? longint'(ib) - (longint'(1) << w) : longint'(ib);
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    sh   = int'(ib % 64'(w));
    e    = '0;
    case (op)
      4'd0: begin
        full = ia + ib; e.res = full & mask; e.c = full[w];
        s = sa + sb; e.v = (s > smax) || (s < smin);
      end
      4'd1: begin
        e.res = (ia - ib) & mask; e.c = (ia < ib);
        s = sa - sb; e.v = (s > smax) || (s < smin);
      end
      4'd2:  e.res = ia & ib;
      4'd3:  e.res = ia | ib;
      4'd4:  e.res = ia ^ ib;
      4'd5:  e.res = ~ia & mask;
      4'd6:  e.res = (ia << sh) & mask;
      4'd7:  e.res = ia >> sh;
      4'd8:  e.res = 64'(ia == ib);
      4'd9:  e.res = 64'(sa < sb);
      4'd10: e.res = 64'(sa <= sb);
      4'd11: begin
        full = ia * ib; e.res = full & mask;
        e.c = ((full >> w) != 64'd0); e.v = e.c; e.lat = w;
      end
      4'd12: if (ib == 64'd0) begin e.res = mask; e.dz = 1'b1; e.lat = 1; end
             else begin e.res = ia / ib; e.lat = w; end
      4'd13: if (ib == 64'd0) begin e.res = ia; e.dz = 1'b1; e.lat = 1; end
             else begin e.res = ia % ib; e.lat = w; end
      4'd14: e.res = 64'(sa >>> sh) & mask;
      default: e.res = 64'd0;
    endcase
    return e;
  endfunction

  // Drive one op into dut16; report edges from accept to out_valid and sampled outputs.
  task automatic issue16(input logic [3:0] op, input logic [15:0] ia, input logic [15:0] ib,
                         output int lat, output int rdy_seen, output logic [20:0] obs);
    int guard = 0;
    while (!in_ready16 && guard < 100) begin @(posedge clk); #1; guard++; end
    in_valid16 = 1'b1; op16 = op; a16 = ia; b16 = ib;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 0; rdy_seen = 0;
    while (!out_valid16 && lat < 100) begin
      if (in_ready16) rdy_seen++;
      @(posedge clk); #1; lat++;
    end
    if (in_ready16) rdy_seen++;
    if (!out_valid16) lat = -1;
    obs = {result16, c16, v16, n16, z16, dz16};
  endtask

  task automatic issue32(input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib,
                         output int lat, output logic [36:0] obs);
    int guard = 0;
    while (!in_ready32 && guard < 100) begin @(posedge clk); #1; guard++; end
    in_valid32 = 1'b1; op32 = op; a32 = ia; b32 = ib;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    lat = 0;
    while (!out_valid32 && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!out_valid32) lat = -1;
    obs = {result32, c32, v32, n32, z32, dz32};
  endtask

  task automatic retire16();
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
  endtask

  task automatic retire32();
    out_ready32 = 1'b1;
    @(posedge clk); #1;
    out_ready32 = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] got;
    logic        quiet;
    reset_n = 1'b0;
    #12;
    got = {in_ready16, out_valid16, result16, z16, c16, v16, n16, dz16};
    n_checks++;
    if (got !== {1'b1, 1'b0, 16'h0000, 1'b1, 4'b0000}) begin
      n_fail++; $display("FAIL reset_state: got %h required %h", got, {1'b1, 1'b0, 16'h0000, 1'b1, 4'b0000});
    end
    @(posedge clk); #1; reset_n = 1'b1;
    @(posedge clk); #1;
    // Start a MUL, then reset while it is iterating.
    in_valid16 = 1'b1; op16 = 4'd11; a16 = 16'h0100; b16 = 16'h0100;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    repeat (5) @(posedge clk);
    #2; reset_n = 1'b0; #1;
    got = {in_ready16, out_valid16, result16, z16, c16, v16, n16, dz16};
    n_checks++;
    if (got !== {1'b1, 1'b0, 16'h0000, 1'b1, 4'b0000}) begin
      n_fail++; $display("FAIL reset_mid_mul: got %h required %h", got, {1'b1, 1'b0, 16'h0000, 1'b1, 4'b0000});
    end
    @(posedge clk); #1; reset_n = 1'b1;
    quiet = 1'b1;
    repeat (20) begin @(posedge clk); #1; if (out_valid16) quiet = 1'b0; end
    n_checks++;
    if (quiet !== 1'b1) begin
      n_fail++; $display("FAIL reset_no_partial: out_valid seen after abort, required none");
    end
  endtask

  task automatic test_add();
    int lat, rs; logic [20:0] obs;
    issue16(4'd0, 16'h7FFF, 16'h0001, lat, rs, obs);
    n_checks++;
    if (lat !== 0) begin n_fail++; $display("FAIL add_latency: got %0d required 0", lat); end
    n_checks++;
    if (obs !== {16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL add_ovf: got %h required %h", obs, {16'h8000, 5'b01100});
    end
    retire16();
    issue16(4'd0, 16'hFFFF, 16'h0001, lat, rs, obs);
    n_checks++;
    if (obs !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL add_carry: got %h required %h", obs, {16'h0000, 5'b10010});
    end
    retire16();
  endtask

  task automatic test_mul();
    int lat, rs; logic [20:0] obs;
    issue16(4'd11, 16'h0100, 16'h0100, lat, rs, obs);
    n_checks++;
    if (lat !== 16) begin n_fail++; $display("FAIL mul_latency: got %0d required 16", lat); end
    n_checks++;
    if (rs !== 0) begin n_fail++; $display("FAIL mul_in_ready_low: in_ready high %0d cycles, required 0", rs); end
    n_checks++;
    if (obs !== {16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL mul_result: got %h required %h", obs, {16'h0000, 5'b11010});
    end
    retire16();
  endtask

  task automatic test_div();
    int lat, rs; logic [20:0] obs;
    issue16(4'd12, 16'd100, 16'd7, lat, rs, obs);
    n_checks++;
    if (lat !== 16 || obs !== {16'd14, 5'b00000}) begin
      n_fail++; $display("FAIL divu: got lat %0d %h required lat 16 %h", lat, obs, {16'd14, 5'b00000});
    end
    retire16();
    issue16(4'd13, 16'd100, 16'd7, lat, rs, obs);
    n_checks++;
    if (lat !== 16 || obs !== {16'd2, 5'b00000}) begin
      n_fail++; $display("FAIL remu: got lat %0d %h required lat 16 %h", lat, obs, {16'd2, 5'b00000});
    end
    retire16();
    issue16(4'd12, 16'd5, 16'd0, lat, rs, obs);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL divzero_latency: got %0d required 1", lat); end
    n_checks++;
    if (obs !== {16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL divzero_result: got %h required %h", obs, {16'hFFFF, 5'b00101});
    end
    retire16();
    issue16(4'd13, 16'h1234, 16'd0, lat, rs, obs);
    n_checks++;
    if (lat !== 1 || obs !== {16'h1234, 5'b00001}) begin
      n_fail++; $display("FAIL remzero: got lat %0d %h required lat 1 %h", lat, obs, {16'h1234, 5'b00001});
    end
    retire16();
  endtask

  task automatic test_backpressure();
    int lat, rs; logic [20:0] obs, held;
    issue16(4'd1, 16'd3, 16'd5, lat, rs, obs);
    n_checks++;
    if (lat !== 0 || obs !== {16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL sub_result: got lat %0d %h required lat 0 %h", lat, obs, {16'hFFFE, 5'b10100});
    end
    for (int k = 0; k < 5; k++) begin
      in_valid16 = (k % 2 == 0); op16 = 4'd0; a16 = 16'h1111; b16 = 16'h2222;
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      held = {result16, c16, v16, n16, z16, dz16};
      n_checks++;
      if (!out_valid16 || in_ready16 || held !== {16'hFFFE, 5'b10100}) begin
        n_fail++; $display("FAIL hold_cycle_%0d: got v%b r%b %h required v1 r0 %h", k, out_valid16, in_ready16, held, {16'hFFFE, 5'b10100});
      end
    end
    retire16();
    n_checks++;
    if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
      n_fail++; $display("FAIL retire: got v%b r%b required v0 r1", out_valid16, in_ready16);
    end
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if (out_valid16 !== 1'b0) begin
      n_fail++; $display("FAIL hold_pulse_accepted: got out_valid %b required 0", out_valid16);
    end
  endtask

  task automatic test_shift32();
    int lat; logic [36:0] obs;
    issue32(4'd14, 32'h80000000, 32'h00000021, lat, obs);
    n_checks++;
    if (lat !== 0 || obs !== {32'hC0000000, 5'b00100}) begin
      n_fail++; $display("FAIL asr32: got lat %0d %h required lat 0 %h", lat, obs, {32'hC0000000, 5'b00100});
    end
    retire32();
    issue32(4'd7, 32'h80000000, 32'h00000021, lat, obs);
    n_checks++;
    if (obs !== {32'h40000000, 5'b00000}) begin
      n_fail++; $display("FAIL shr32: got %h required %h", obs, {32'h40000000, 5'b00000});
    end
    retire32();
  endtask

  task automatic test_random();
    int lat, rs; logic [20:0] obs, want; logic [36:0] obs32, want32;
    exp_t e; logic [3:0] op; logic [63:0] ia, ib;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      ia = 64'($urandom & 32'h0000FFFF);
      ib = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : 64'($urandom & 32'h0000FFFF);
      e = model(16, op, ia, ib);
      want = {e.res[15:0], e.c, e.v, e.res[15], e.res[15:0] == 16'h0, e.dz};
      issue16(op, ia[15:0], ib[15:0], lat, rs, obs);
      n_checks++;
      if (lat !== e.lat || obs !== want) begin
        n_fail++; $display("FAIL rand16 op%0d a=%h b=%h: got lat %0d %h required lat %0d %h", op, ia[15:0], ib[15:0], lat, obs, e.lat, want);
      end
      retire16();
    end
    for (int i = 0; i < 20; i++) begin
      op = 4'($urandom_range(0, 15));
      ia = 64'($urandom);
      ib = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 40)) : 64'($urandom);
      e = model(32, op, ia, ib);
      want32 = {e.res[31:0], e.c, e.v, e.res[31], e.res[31:0] == 32'h0, e.dz};
      issue32(op, ia[31:0], ib[31:0], lat, obs32);
      n_checks++;
      if (lat !== e.lat || obs32 !== want32) begin
        n_fail++; $display("FAIL rand32 op%0d a=%h b=%h: got lat %0d %h required lat %0d %h", op, ia[31:0], ib[31:0], lat, obs32, e.lat, want32);
      end
      retire32();
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] obs, want; exp_t e; logic [3:0] op; logic [63:0] ia, ib;
    int pick;
    out_ready16 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pick = $urandom_range(0, 12);
      op = (pick > 10) ? 4'(pick + 3) : 4'(pick);
      ia = 64'($urandom & 32'h0000FFFF);
      ib = 64'($urandom & 32'h0000FFFF);
      e = model(16, op, ia, ib);
      want = {e.res[15:0], e.c, e.v, e.res[15], e.res[15:0] == 16'h0, e.dz};
      in_valid16 = 1'b1; op16 = op; a16 = ia[15:0]; b16 = ib[15:0];
      @(posedge clk); #1;
      obs = {result16, c16, v16, n16, z16, dz16};
      n_checks++;
      if (!out_valid16 || obs !== want) begin
        n_fail++; $display("FAIL b2b_result_%0d op%0d: got v%b %h required v1 %h", i, op, out_valid16, obs, want);
      end
      @(posedge clk); #1;
      n_checks++;
      if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0) begin
        n_fail++; $display("FAIL b2b_idle_%0d: got r%b v%b required r1 v0", i, in_ready16, out_valid16);
      end
    end
    in_valid16  = 1'b0;
    out_ready16 = 1'b0;
  endtask

  initial begin
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; op16 = '0;
    in_valid32 = 1'b0; out_ready32 = 1'b0; a32 = '0; b32 = '0; op32 = '0;
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_backpressure();
    test_shift32();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
